// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, blanking constant and width helper for the segment scanner
package seg_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_OFF = 8'h00;
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    return SEG_GLYPH[n];
  endfunction
  function automatic int seg_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: per-digit slot counter and digit index with frame-boundary flag
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int SLOT = 50000,
  parameter int DIGITS = 8,
  localparam int SW = seg_cw(SLOT),
  localparam int IW = seg_cw(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [SW-1:0] o_slot,
  output logic [IW-1:0] o_idx,
  output logic          o_frame
);
  logic [SW-1:0] r_slot;
  logic [IW-1:0] r_idx;
  logic w_swrap, w_iwrap;
  assign w_swrap = r_slot == SW'(SLOT - 1);
  assign w_iwrap = r_idx == IW'(DIGITS - 1);
  assign o_frame = w_swrap && w_iwrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else begin
      r_slot <= w_swrap ? '0 : r_slot + SW'(1);
      if (w_swrap) r_idx <= w_iwrap ? '0 : r_idx + IW'(1);
    end
  assign o_slot = r_slot;
  assign o_idx  = r_idx;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous updates and PWM dimming.
// Define SEG_BLINK_EN to add the blink_mask port and a 2 Hz blink phase.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_FREQ = 1000,
  parameter int DIGITS = 8,
  parameter int SEL_ACT_HIGH = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_supp,
  input  logic                  load,
  input  logic [3:0]            duty,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  upd_done
);
  localparam int SLOT = CLK_FREQ / SCAN_FREQ;
  localparam int SW = seg_cw(SLOT);
  localparam int IW = seg_cw(DIGITS);
  localparam int PW = SW + 5;
  logic [SW-1:0] w_slot;
  logic [IW-1:0] w_idx;
  logic w_frame;
  logic [4*DIGITS-1:0] r_p_data, r_a_data;
  logic [DIGITS-1:0] r_p_dp, r_a_dp, r_p_en, r_a_en, r_sel;
  logic r_p_lz, r_a_lz, r_p_flag, r_upd;
  seg_t r_seg, w_seg;
  logic [DIGITS-1:0] w_lz, w_sel;
  logic [PW-1:0] w_lim;
  logic [3:0] w_nib;
  logic w_on, w_blank, w_blink, w_run;

  seg_scan_tick #(.SLOT(SLOT), .DIGITS(DIGITS)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_slot (w_slot),
    .o_idx  (w_idx),
    .o_frame(w_frame)
  );

  // A load on the boundary cycle bypasses pending so it is not a frame late
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p_data <= '0;
      r_p_dp   <= '0;
      r_p_en   <= '0;
      r_p_lz   <= 1'b0;
      r_a_data <= '0;
      r_a_dp   <= '0;
      r_a_en   <= '0;
      r_a_lz   <= 1'b0;
      r_p_flag <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      if (load) begin
        r_p_data <= disp_data;
        r_p_dp   <= dp_in;
        r_p_en   <= digit_en;
        r_p_lz   <= lz_supp;
      end
      if (w_frame) begin
        r_a_data <= load ? disp_data : r_p_data;
        r_a_dp   <= load ? dp_in : r_p_dp;
        r_a_en   <= load ? digit_en : r_p_en;
        r_a_lz   <= load ? lz_supp : r_p_lz;
      end
      r_p_flag <= !w_frame && (r_p_flag || load);
      r_upd    <= w_frame && (r_p_flag || load);
    end

  // Disabled digits are transparent to the leading-zero run
  always_comb begin
    w_lz = '0;
    w_run = r_a_lz;
    for (int i = DIGITS - 1; i > 0; i--)
      if (r_a_en[i]) begin
        w_lz[i] = w_run && (r_a_data[4*i +: 4] == 4'h0) && !r_a_dp[i];
        w_run = w_lz[i];
      end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK = CLK_FREQ / 4;
  localparam int BW = seg_cw(BLINK);
  logic [BW-1:0] r_bcnt;
  logic r_bph;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (r_bcnt == BW'(BLINK - 1)) begin
      r_bcnt <= '0;
      r_bph  <= ~r_bph;
    end else
      r_bcnt <= r_bcnt + BW'(1);
  assign w_blink = r_bph && blink_mask[w_idx];
`else
  assign w_blink = 1'b0;
`endif

  assign w_lim   = PW'(((PW'(duty) + PW'(1)) * PW'(SLOT)) >> 4);
  assign w_on    = PW'(w_slot) < w_lim;
  assign w_nib   = r_a_data[4*w_idx +: 4];
  assign w_blank = !r_a_en[w_idx] || w_lz[w_idx] || w_blink;
  assign w_seg   = w_blank ? SEG_OFF : {r_a_dp[w_idx], seg_glyph(w_nib)};
  assign w_sel   = w_on ? DIGITS'(1) << w_idx : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sel <= (SEL_ACT_HIGH != 0) ? '0 : '1;
      r_seg <= (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    end else begin
      r_sel <= (SEL_ACT_HIGH != 0) ? w_sel : ~w_sel;
      r_seg <= (SEG_ACT_LOW != 0) ? ~w_seg : w_seg;
    end

  assign sel      = r_sel;
  assign seg      = r_seg;
  assign upd_done = r_upd;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frame checks with an expected-output queue, plus corner sequences
module tb_seg_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0] dp_in = '0, digit_en = '0;
  logic lz_supp = 1'b0, load = 1'b0;
  logic [3:0] duty = 4'hF;
`ifdef SEG_BLINK_EN
  logic [7:0] blink_mask = '0;
`endif
  logic [7:0] sel, seg;
  logic upd_done;
  int n_vec = 0, n_miss = 0;
  int cyc;

  typedef struct {
    logic [31:0] data;
    logic [7:0] dp, en;
    logic lz;
    logic [3:0] duty;
    logic [7:0][7:0] exp;
    int on;
  } vec_t;
  typedef struct packed {
    logic [7:0] sel, seg;
    logic upd;
  } obs_t;
  vec_t tbl[6];
  obs_t q[$];

  seg_scan_ctrl #(.CLK_FREQ(1600), .SCAN_FREQ(100), .DIGITS(8), .SEL_ACT_HIGH(1), .SEG_ACT_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .disp_data(disp_data), .dp_in(dp_in), .digit_en(digit_en), .lz_supp(lz_supp),
    .load(load), .duty(duty), .sel(sel), .seg(seg), .upd_done(upd_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dig(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic push_frame(input logic [7:0][7:0] exp, input int on);
    for (int k = 0; k < 128; k++)
      q.push_back({((k % 16) < on) ? 8'(1 << (k / 16)) : 8'h00, exp[k / 16], 1'b0});
  endtask

  task automatic drain(input string name);
    obs_t e;
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      check({name, " sel"}, sel, e.sel);
      check({name, " seg"}, seg, e.seg);
      check({name, " upd_done"}, upd_done, e.upd);
    end
  endtask

  task automatic do_load(input vec_t v);
    disp_data = v.data;
    dp_in = v.dp;
    digit_en = v.en;
    lz_supp = v.lz;
    duty = v.duty;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_upd(input string name);
    int t = 0;
    while (upd_done !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    check({name, " upd_done seen"}, upd_done, 1);
  endtask

  task automatic wait_sel(input logic [7:0] s);
    int t = 0;
    while (sel !== s && t < 400) begin
      tick();
      t++;
    end
    check("wait for sel", sel, s);
  endtask

  initial begin
    vec_t v1, v2;
    logic [7:0][7:0] blank;
    int t, nupd;
    blank = {8{8'hFF}};
    tbl[0] = '{32'h0123_89AB, 8'h00, 8'hFF, 1'b0, 4'hF, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h80, 8'h90, 8'h88, 8'h83}, 16};
    tbl[1] = '{32'h0000_0000, 8'h00, 8'hFF, 1'b1, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, 16};
    tbl[2] = '{32'h0000_0450, 8'h08, 8'hFF, 1'b1, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h99, 8'h92, 8'hC0}, 16};
    tbl[3] = '{32'h4567_CDEF, 8'h00, 8'hFF, 1'b0, 4'h3, {8'h99, 8'h92, 8'h82, 8'hF8, 8'hC6, 8'hA1, 8'h86, 8'h8E}, 4};
    tbl[4] = '{32'h1111_1111, 8'hFF, 8'h0F, 1'b0, 4'h0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h79, 8'h79, 8'h79, 8'h79}, 1};
    tbl[5] = '{32'h0000_0012, 8'h00, 8'h7F, 1'b1, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4}, 16};
    v1 = '{32'h1111_1111, 8'h00, 8'hFF, 1'b0, 4'hF, {8{8'hF9}}, 16};
    v2 = '{32'h2222_2222, 8'h00, 8'hFF, 1'b0, 4'hF, {8{8'hA4}}, 16};

    repeat (3) tick();
    check("reset sel", sel, 8'h00);
    check("reset seg", seg, 8'hFF);
    check("reset upd_done", upd_done, 0);
    @(negedge clk) rst_n = 1'b1;
    push_frame(blank, 16);
    drain("post-reset frame");

    for (int i = 0; i < 6; i++) begin
      do_load(tbl[i]);
      wait_upd($sformatf("vec%0d", i));
      push_frame(tbl[i].exp, tbl[i].on);
      drain($sformatf("vec%0d", i));
    end

    wait_sel(8'h08);
    do_load(v1);
    t = 0;
    while (sel !== 8'h20 && t < 200) begin
      if (sel != 8'h00) check("midframe old seg", seg, tbl[5].exp[dig(sel)]);
      tick();
      t++;
    end
    check("midframe reach digit 5", sel, 8'h20);
    do_load(v2);
    t = 0;
    while (upd_done !== 1'b1 && t < 200) begin
      if (sel != 8'h00) check("midframe old seg", seg, tbl[5].exp[dig(sel)]);
      tick();
      t++;
    end
    check("midframe upd_done", upd_done, 1);
    push_frame(v2.exp, 16);
    drain("midframe new frame");

    wait_sel(8'h40);
    wait_sel(8'h80);
    repeat (14) tick();
    do_load(tbl[0]);
    check("boundary load upd_done", upd_done, 1);
    push_frame(tbl[0].exp, 16);
    drain("boundary load frame");

    nupd = 0;
    repeat (140) begin
      tick();
      if (upd_done) nupd++;
    end
    check("no load no upd_done", nupd, 0);

    wait_sel(8'h20);
    do_load(tbl[2]);
    #1 rst_n = 1'b0;
    #1;
    check("midreset sel", sel, 8'h00);
    check("midreset seg", seg, 8'hFF);
    check("midreset upd_done", upd_done, 0);
    @(negedge clk) rst_n = 1'b1;
    push_frame(blank, 16);
    push_frame(blank, 16);
    drain("after midreset");

`ifdef SEG_BLINK_EN
    blink_mask = 8'h01;
    do_load(tbl[0]);
    wait_upd("blink");
    repeat (1600) begin
      tick();
      if (sel == 8'h01) check("blink digit0 seg", seg, (((cyc - 1) / 400) % 2) ? 8'hFF : 8'h83);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, which is the clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_FREQ, default 1000, which is the per-digit slot rate in Hz.
REQ-003 SHALL have parameter DIGITS, default 8, which is the number of digits (2..16).
REQ-004 SHALL have parameter SEL_ACT_HIGH, default 1; 1 means an active digit select is driven 1.
REQ-005 SHALL have parameter SEG_ACT_LOW, default 1; 1 means a lit segment or dp is driven 0.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-008 SHALL have port disp_data, input, 4*DIGITS bits: hex nibbles, with digit i at [4i+3:4i].
REQ-009 SHALL have port dp_in, input, DIGITS bits: per-digit decimal point.
REQ-010 SHALL have port digit_en, input, DIGITS bits: per-digit enable, where 0 blanks the digit.
REQ-011 SHALL have port lz_supp, input, 1 bit: leading-zero suppression enable.
REQ-012 SHALL have port load, input, 1 bit: a one-cycle capture strobe for disp_data, dp_in, digit_en and lz_supp.
REQ-013 SHALL have port duty, input, 4 bits: brightness, sampled continuously.
REQ-014 SHALL have port blink_mask, input, DIGITS bits: per-digit blink; this port exists only with SEG_BLINK_EN.
REQ-015 SHALL have port sel, output, DIGITS bits: the one-hot digit select.
REQ-016 SHALL have port seg, output, 8 bits: {dp,g,f,e,d,c,b,a}.
REQ-017 SHALL have port upd_done, output, 1 bit: a one-cycle pulse when the pending data becomes active.

Function
REQ-018 SHALL count a slot counter 0..SLOT-1, where SLOT=CLK_FREQ/SCAN_FREQ; the counter wraps at SLOT-1 and advances the digit index.
REQ-019 SHALL advance the digit index 0..DIGITS-1 and wrap it to 0; the cycle on which it wraps is the frame boundary.
REQ-020 SHALL copy the inputs into a pending register on load; if several loads occur within one frame, the last load wins.
REQ-021 SHALL commit the pending register to the active register only at a frame boundary, so that no frame ever shows mixed data.
REQ-022 SHALL commit the new input values directly when load coincides with a frame boundary.
REQ-023 SHALL assert upd_done on the cycle after a commit, and only when a load occurred since the previous commit.
REQ-024 SHALL register sel and seg, giving exactly 1 cycle of latency from the slot counter and index to the outputs.
REQ-025 SHALL drive sel active during a slot only while slotcnt < ((duty+1)*SLOT)>>4; outside that window all of sel is inactive.
REQ-026 SHALL make duty=15 give a full slot.
REQ-027 SHALL use the standard hex glyphs 0-F for seg, with dp from the active dp bit.
REQ-028 SHALL drive all segments including dp off when a digit is blanked.
REQ-029 SHALL keep sel active for a blanked digit (PWM rules still apply).
REQ-030 SHALL blank a digit when its digit_en bit is 0.
REQ-031 SHALL, with lz_supp set, blank zero nibbles starting at the highest enabled digit and moving down until the first nonzero nibble.
REQ-032 SHALL never blank digit 0 through leading-zero suppression.
REQ-033 SHALL not treat a digit with dp set as a leading zero.
REQ-034 SHALL apply the SEL_ACT_HIGH and SEG_ACT_LOW polarity only at the output registers.

Reset
REQ-035 SHALL, on reset, clear the slot counter, index, pending and active registers, the load flag and upd_done to 0.
REQ-036 SHALL drive sel to the inactive level on reset: all 0 with SEL_ACT_HIGH=1, all 1 otherwise.
REQ-037 SHALL drive seg to all segments off on reset: 8'hFF with SEG_ACT_LOW=1, 8'h00 otherwise.
REQ-038 SHALL, after reset release, produce its first active sel for digit 0 on the cycle after the first clock edge.
REQ-039 SHALL discard any pending load when reset is asserted mid-frame.

Configuration
REQ-040 SHALL support the macro SEG_BLINK_EN.
REQ-041 SHALL, when SEG_BLINK_EN is defined, include a blink_mask port and toggle a blink phase every CLK_FREQ/4 cycles (2 Hz blink).
REQ-042 SHALL, when SEG_BLINK_EN is defined and the blink phase is 1, blank the masked digits; blink_mask bypasses the pending and active registers.
REQ-043 SHALL, when SEG_BLINK_EN is not defined, include no blink_mask port, no blink counter and no blink logic.

Structure
REQ-044 SHALL place the 16-entry active-high glyph table and the glyph function in the shared package seg_pkg.
REQ-045 SHALL place a SEG_OFF constant in seg_pkg.
REQ-046 SHALL place a clog2-based width helper in seg_pkg.
REQ-047 SHALL implement the slot counter and the index/frame-boundary generator as the sub-module seg_scan_tick.

Verification
REQ-048 SHALL verify basic scanning: with CLK_FREQ=1600, SCAN_FREQ=100 (SLOT=16), DIGITS=8, load 32'h0123_89AB, all digit_en=1, duty=15 -> sel steps 01,02,...,80 every 16 cycles, and seg=C0,F9,A4,B0 for digits 7..4 and 80,90,88,83 for digits 3..0.
REQ-049 SHALL verify mid-frame load: load 32'h1111_1111 at digit 3, then 32'h2222_2222 at digit 5 -> the current frame is unchanged, the next frame shows only 2s, and upd_done pulses once.
REQ-050 SHALL verify leading-zero suppression: lz_supp=1, load 32'h0000_0000 -> digits 7..1 show seg=FF and digit 0 shows C0.
REQ-051 SHALL verify leading-zero suppression with dp: 32'h0000_0450 with dp_in[3]=1 -> digits 7..4 are blank and digit 3 shows 0 with dp lit (40).
REQ-052 SHALL verify brightness: duty=3 -> sel is active for 4 of 16 cycles per slot; duty=0 -> active for 1 cycle.
REQ-053 SHALL verify reset mid-frame: assert rst_n low during digit 5 -> sel=00 and seg=FF immediately, and after release the display restarts at digit 0 with the active data cleared to 0.
REQ-054 SHALL verify blink with SEG_BLINK_EN defined: blink_mask=8'h01 -> digit 0 alternates between blank and its glyph every CLK_FREQ/4 cycles.
